// File: rtl/fivexn_bit_demux.sv
// fivexn_bit_demux: routes one valid/ready input stream into five one-entry output channels.
// Illegal selects (5..7) are always accepted, dropped, pulsed on err and counted.
module fivexn_bit_demux #(
  parameter int width = 1,
  parameter int errw  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out0,
  output logic [width-1:0] out1,
  output logic [width-1:0] out2,
  output logic [width-1:0] out3,
  output logic [width-1:0] out4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic             err,
  output logic [errw-1:0]  err_count
);
  logic [width-1:0] r_data [5];
  logic [4:0]       r_valid;
  logic             r_err;
  logic [errw-1:0]  r_cnt;
  logic [4:0]       w_sel_oh;
  logic [4:0]       w_ch_ready;
  logic [4:0]       w_load;
  logic             w_legal;
  logic             w_fire;
  logic             w_drop;
  // one-hot is all zero for selects 5..7, which marks them illegal
  assign w_sel_oh   = 5'b00001 << in_sel;
  assign w_legal    = |w_sel_oh;
  assign w_ch_ready = ~r_valid | out_ready;
  assign in_ready   = w_legal ? |(w_sel_oh & w_ch_ready) : 1'b1;
  assign w_fire     = in_valid && in_ready;
  assign w_load     = w_fire ? w_sel_oh : 5'b00000;
  assign w_drop     = w_fire && !w_legal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= (r_valid & ~out_ready) | w_load;
      r_err   <= w_drop;
      if (w_drop && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  for (genvar k = 0; k < 5; k++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_data[k] <= '0;
      else if (w_load[k]) r_data[k] <= in_data;
  end
  assign out0      = r_data[0];
  assign out1      = r_data[1];
  assign out2      = r_data[2];
  assign out3      = r_data[3];
  assign out4      = r_data[4];
  assign out_valid = r_valid;
  assign err       = r_err;
  assign err_count = r_cnt;
endmodule

// File: tb/tb_fivexn_bit_demux.sv
// tb_fivexn_bit_demux: directed and randomized checks of the five-way demux against an array-based model.
module tb_fivexn_bit_demux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0;
  logic [2:0] in_sel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out0, out1, out2, out3, out4;
  logic [4:0] out_valid;
  logic [4:0] out_ready = '0;
  logic       err;
  logic [1:0] err_count;
  logic [3:0] outs [5];
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] md [5];
  logic [4:0] mv;
  logic       merr;
  int         mcnt;

  always #5 clk = ~clk;

  fivexn_bit_demux #(.width(4), .errw(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .err_count(err_count)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;

  function automatic logic m_ready(input logic [2:0] s, input logic [4:0] rdy);
    return (s > 3'd4) ? 1'b1 : (!mv[s] || rdy[s]);
  endfunction

  task automatic m_clear();
    mv = '0;
    merr = 1'b0;
    mcnt = 0;
    for (int k = 0; k < 5; k++) md[k] = '0;
  endtask

  task automatic drive(input logic [3:0] d, input logic [2:0] s, input logic v, input logic [4:0] rdy);
    in_data = d;
    in_sel = s;
    in_valid = v;
    out_ready = rdy;
    #1;
  endtask

  // advance one clock and apply the transfer rules to the model
  task automatic tick();
    logic fire;
    logic [2:0] s;
    logic [3:0] d;
    logic [4:0] rdy;
    s = in_sel;
    d = in_data;
    rdy = out_ready;
    fire = in_valid && m_ready(s, rdy);
    @(posedge clk);
    mv = mv & ~rdy;
    if (fire && s < 3'd5) begin
      md[s] = d;
      mv[s] = 1'b1;
    end
    merr = fire && s > 3'd4;
    if (merr && mcnt < 3) mcnt++;
    #1;
  endtask

  task automatic test_reset();
    m_clear();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 5'b0 || err !== 1'b0 || err_count !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b err=%b cnt=%0d want 00000 0 0", out_valid, err, err_count);
    end
    n_cmp++;
    if ({out0, out1, out2, out3, out4} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00000", {out0, out1, out2, out3, out4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) begin
      drive(4'h0, 3'(s), 1'b0, 5'b0);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_ready sel=%0d: got %b want 1", s, in_ready);
      end
    end
  endtask

  task automatic test_fill_drain();
    drive(4'hA, 3'd2, 1'b1, 5'b0);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++;
    if (out2 !== 4'hA || out_valid !== 5'b00100) begin
      n_bad++;
      $display("FAIL fill_load: out2=%h valid=%b want a 00100", out2, out_valid);
    end
    drive(4'hB, 3'd2, 1'b1, 5'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++;
    if (out2 !== 4'hA || out_valid !== 5'b00100) begin
      n_bad++;
      $display("FAIL full_hold: out2=%h valid=%b want a 00100", out2, out_valid);
    end
    drive(4'hB, 3'd2, 1'b1, 5'b00100);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_fill_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++;
    if (out2 !== 4'hB || out_valid !== 5'b00100) begin
      n_bad++;
      $display("FAIL drain_fill: out2=%h valid=%b want b 00100", out2, out_valid);
    end
    drive(4'h0, 3'd2, 1'b0, 5'b00100);
    tick();
    n_cmp++;
    if (out_valid !== 5'b0) begin n_bad++; $display("FAIL drain_only: valid=%b want 00000", out_valid); end
  endtask

  task automatic test_independence();
    logic [2:0] sels [3] = '{3'd0, 3'd1, 3'd3};
    drive(4'h7, 3'd4, 1'b1, 5'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 1), sels[i], 1'b1, 5'b01011);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL indep_ready sel=%0d: got %b want 1", sels[i], in_ready); end
      tick();
      n_cmp++;
      if (out_valid[sels[i]] !== 1'b1 || outs[sels[i]] !== 4'(i + 1) || out4 !== 4'h7 || out_valid[4] !== 1'b1) begin
        n_bad++;
        $display("FAIL indep_load sel=%0d: data=%h valid=%b out4=%h want %h v=1 out4=7",
                 sels[i], outs[sels[i]], out_valid, out4, 4'(i + 1));
      end
    end
    drive(4'h9, 3'd4, 1'b1, 5'b01011);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stalled_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++;
    if (out4 !== 4'h7 || out_valid !== mv) begin
      n_bad++;
      $display("FAIL stalled_hold: out4=%h valid=%b want 7 %b", out4, out_valid, mv);
    end
    drive(4'h0, 3'd0, 1'b0, 5'b11111);
    tick();
  endtask

  task automatic test_back_to_back_illegal();
    logic [4:0] v0;
    v0 = out_valid;
    for (int i = 0; i < 3; i++) begin
      drive(4'(i), 3'd6, 1'b1, 5'b0);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_ready: got %b want 1", in_ready); end
      tick();
      n_cmp++;
      if (err !== 1'b1 || err_count !== 2'(i + 1) || out_valid !== v0) begin
        n_bad++;
        $display("FAIL illegal_cycle%0d: err=%b cnt=%0d valid=%b want 1 %0d %b", i, err, err_count, out_valid, i + 1, v0);
      end
    end
    drive(4'h0, 3'd7, 1'b0, 5'b0);
    tick();
    n_cmp++;
    if (err !== 1'b0 || err_count !== 2'd3) begin
      n_bad++;
      $display("FAIL illegal_idle: err=%b cnt=%0d want 0 3", err, err_count);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'h0, 3'd5, 1'b1, 5'b0);
      tick();
    end
    n_cmp++;
    if (err !== 1'b1 || err_count !== 2'd3) begin
      n_bad++;
      $display("FAIL saturate: err=%b cnt=%0d want 1 3", err, err_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 5'($urandom));
      n_cmp++;
      if (in_ready !== m_ready(in_sel, out_ready)) begin
        n_bad++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, m_ready(in_sel, out_ready));
      end
      tick();
      n_cmp++;
      if (out_valid !== mv || err !== merr || err_count !== 2'(mcnt)) begin
        n_bad++;
        $display("FAIL rand_state c=%0d: valid=%b err=%b cnt=%0d want %b %b %0d", c, out_valid, err, err_count, mv, merr, mcnt);
      end
      for (int k = 0; k < 5; k++)
        if (mv[k]) begin
          n_cmp++;
          if (outs[k] !== md[k]) begin
            n_bad++;
            $display("FAIL rand_data c=%0d ch=%0d: got %h want %h", c, k, outs[k], md[k]);
          end
        end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'(k + 3), 3'(k), 1'b1, 5'b0);
      tick();
    end
    drive(4'h0, 3'd0, 1'b0, 5'b0);
    n_cmp++;
    if (out_valid !== 5'b11111) begin n_bad++; $display("FAIL all_full: valid=%b want 11111", out_valid); end
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    n_cmp++;
    if (out_valid !== 5'b0 || {out0, out1, out2, out3, out4} !== 20'h0 || err !== 1'b0 || err_count !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b data=%h err=%b cnt=%0d want all zero",
               out_valid, {out0, out1, out2, out3, out4}, err, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (out_valid !== 5'b0) begin n_bad++; $display("FAIL post_reset_idle: valid=%b want 00000", out_valid); end
    drive(4'hC, 3'd1, 1'b1, 5'b0);
    tick();
    n_cmp++;
    if (out_valid !== 5'b00010 || out1 !== 4'hC) begin
      n_bad++;
      $display("FAIL post_reset_accept: valid=%b out1=%h want 00010 c", out_valid, out1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_independence();
    test_back_to_back_illegal();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
